// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, active/sync decode, a
// pixel-pipeline alignment delay line and line/frame start strobes.
module vga_timing_gen_chk #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_SYNC   = 96,
    parameter int V_SYNC   = 2,
    parameter int PIPE_DLY = 2,
    parameter int CNT_W    = 10
) ();
    if (H_SYNC < 1) begin : g_err_hsync
        $error("vga_timing_gen: H_SYNC must be at least 1");
    end
    if (V_SYNC < 1) begin : g_err_vsync
        $error("vga_timing_gen: V_SYNC must be at least 1");
    end
    if ((PIPE_DLY < 1) || (PIPE_DLY > 8)) begin : g_err_dly
        $error("vga_timing_gen: PIPE_DLY must be in 1..8");
    end
    if ((H_TOTAL - 1) >= (2 ** CNT_W)) begin : g_err_hcnt
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL");
    end
    if ((V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_err_vcnt
        $error("vga_timing_gen: CNT_W too narrow for V_TOTAL");
    end
endmodule

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE_DLY = 2,
    parameter int CNT_W    = 10
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_pix_req,
    output logic             o_video,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_line_start,
    output logic             o_frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] X_HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] X_HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] Y_VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] Y_VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Sync stages hold the final pin level so the outputs come straight from flops.
    localparam logic HS_ON  = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_OFF = ~VS_ON;

    logic [CNT_W-1:0]    r_x;
    logic [CNT_W-1:0]    r_y;
    logic                w_x_wrap;
    logic                w_y_wrap;
    logic                w_act;
    logic                w_hs_lvl;
    logic                w_vs_lvl;
    logic [PIPE_DLY-1:0] r_vid;
    logic [PIPE_DLY-1:0] r_hs;
    logic [PIPE_DLY-1:0] r_vs;
    logic                r_line_start;
    logic                r_frame_start;

    vga_timing_gen_chk #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_SYNC  (H_SYNC),
        .V_SYNC  (V_SYNC),
        .PIPE_DLY(PIPE_DLY),
        .CNT_W   (CNT_W)
    ) u_chk ();

    assign w_x_wrap = (r_x == X_LAST);
    assign w_y_wrap = (r_y == Y_LAST);
    assign w_act    = (r_x < X_ACT) && (r_y < Y_ACT);
    assign w_hs_lvl = ((r_x >= X_HS_BEG) && (r_x < X_HS_END)) ? HS_ON : HS_OFF;
    assign w_vs_lvl = ((r_y >= Y_VS_BEG) && (r_y < Y_VS_END)) ? VS_ON : VS_OFF;

    // Raster counters: x sweeps the line, y steps once per line wrap.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_y_wrap ? '0 : (r_y + CNT_ONE);
            end else begin
                r_x <= r_x + CNT_ONE;
            end
        end
    end

    // Alignment delay line for video/hsync/vsync, shifted only on pixel ticks.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vid <= '0;
            r_hs  <= {PIPE_DLY{HS_OFF}};
            r_vs  <= {PIPE_DLY{VS_OFF}};
        end else if (i_en) begin
            r_vid[0] <= w_act;
            r_hs[0]  <= w_hs_lvl;
            r_vs[0]  <= w_vs_lvl;
            for (int k = 1; k < PIPE_DLY; k++) begin
                r_vid[k] <= r_vid[k-1];
                r_hs[k]  <= r_hs[k-1];
                r_vs[k]  <= r_vs[k-1];
            end
        end
    end

    // Start strobes last exactly one clock, whatever i_en does next.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= i_en & w_x_wrap;
            r_frame_start <= i_en & w_x_wrap & w_y_wrap;
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_pix_req     = w_act;
    assign o_video       = r_vid[PIPE_DLY-1];
    assign o_hsync       = r_hs[PIPE_DLY-1];
    assign o_vsync       = r_vs[PIPE_DLY-1];
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates raster counters, video-active, hsync and vsync for any mode, with selectable sync polarity and a pixel-clock enable so it can run from a faster system clock. A configurable delay line aligns the sync and video outputs with a downstream pixel pipeline, for example the frame-buffer read latency in the OV7670 capture-to-VGA path. Frame-start and line-start strobes drive the frame-buffer address generator.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
PIPE_DLY, 2, enabled ticks between counter state and o_video/o_hsync/o_vsync; legal range 1..8
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_en  in  1  pixel tick; all state advances only when i_en=1
o_x  out  CNT_W  horizontal counter, 0..H_TOTAL-1
o_y  out  CNT_W  vertical counter, 0..V_TOTAL-1
o_pix_req  out  1  undelayed active region; aligned with o_x/o_y
o_video  out  1  active region, delayed by PIPE_DLY ticks
o_hsync  out  1  hsync at HS_POL level, delayed by PIPE_DLY ticks
o_vsync  out  1  vsync at VS_POL level, delayed by PIPE_DLY ticks
o_line_start  out  1  one-i_clk strobe when o_x becomes 0
o_frame_start  out  1  one-i_clk strobe when (o_x,o_y) becomes (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset (i_rstn=0, asynchronous, any time including mid-frame):
  - o_x=0, o_y=0, o_line_start=0, o_frame_start=0.
  - Every delay stage is set inactive: video 0, hsync ~HS_POL, vsync ~VS_POL.
  - On release, counting resumes from (0,0) on the first i_en tick. No strobe is issued for the reset-time (0,0).
- Counters are registered and advance on i_clk edges where i_en=1:
  - If x==H_TOTAL-1: x becomes 0, and y increments, or wraps to 0 when y==V_TOTAL-1.
  - Otherwise x increments and y holds.
  - When i_en=0, counters and the delay line hold.
- Decode from the current counters:
  - act = (x<H_ACTIVE) && (y<V_ACTIVE). o_pix_req = act, combinational from the registered counters.
  - hs_act = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. Vsync is line-based and independent of x.
- Delay line: PIPE_DLY registered stages of {act, hs_act, vs_act}. Stage 0 loads the decode; stage k loads stage k-1. Shifting happens only when i_en=1.
  - o_video = last stage video bit.
  - o_hsync = HS_POL if the last-stage hs bit is set, else ~HS_POL. o_vsync uses VS_POL the same way.
  - Latency: o_video at clk edge n+PIPE_DLY enabled ticks equals o_pix_req at tick n.
- Strobes are registered:
  - o_line_start=1 for exactly one i_clk cycle after any enabled tick that wraps x.
  - o_frame_start=1 for one i_clk cycle after an enabled tick that wraps both x and y. o_line_start is also 1 in that cycle.
  - Strobes deassert on the next i_clk edge regardless of i_en.
- Default mode timing:
  - 800x525 ticks per frame, 420000 ticks total.
  - Undelayed hsync active for x=656..751; vsync active for y=490..491.
- The block has no error outputs. Illegal parameters (a zero-width sync, or a counter overflowing CNT_W) are flagged by elaboration-time assertions in simulation.

Test Plan:
1. Default params, i_en tied 1, reset pulse → o_x, o_y, o_video=0, o_hsync=1, o_vsync=1 during reset. First o_line_start 800 clks after release; first o_frame_start 420000 clks after release.
2. Default params, scan one line → o_pix_req=1 for x=0..639. o_video goes 1 exactly 2 clks after o_pix_req and goes 0 2 clks after x=640. o_hsync is low for 96 clks, starting 2 clks after x=656.
3. Default params, full frame → o_vsync low for exactly 1600 enabled ticks, starting when y=490, x=0 reaches the output stage. o_video is never 1 while y≥480.
4. Small mode (H 8/2/3/1, V 4/1/2/1, HS_POL=VS_POL=1, PIPE_DLY=3) → H_TOTAL=14, V_TOTAL=8. o_hsync is high for x=10..12 (delayed 3). o_vsync is high for y=5..6. The frame repeats every 112 ticks.
5. i_en asserted 1 clk in 4, default params → all outputs advance once per enabled tick. Strobes are 1 clk wide. Line period is 3200 clks.
6. Assert i_rstn=0 asynchronously mid-line at x=300, y=200 with no clock edge → outputs go to reset values immediately. After release, the next o_line_start comes after 800 enabled ticks.
